// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C slave engine.
// Pure declarations: no logic, no latency, no flow control.
package i2c_pkg;

  localparam int BYTE_BITS = 8;
  localparam int ADDR_BITS = 7;

  // bit_cnt value after the last data bit of a byte has been clocked
  localparam logic [3:0] BIT_CNT_FULL = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  function automatic logic addr_hit(input logic [BYTE_BITS-1:0] addr_byte,
                                    input logic [ADDR_BITS-1:0] slave_addr);
    return addr_byte[BYTE_BITS-1:1] == slave_addr;
  endfunction

endpackage

// File: rtl/i2c_slave_shifter_if.sv
// Bus-side bundle of the I2C slave shifter: synchronized lines, framing pulses, byte data.
// Wires only; tx_req/tx_data form a request/supply pair, no other backpressure.
interface i2c_slave_shifter_if;
  import i2c_pkg::*;

  logic                 sda_i;
  logic                 scl_i;
  logic                 start_detected_i;
  logic                 transfer_in_progress_i;
  logic [BYTE_BITS-1:0] tx_data_i;
  logic                 sda_oe_o;
  logic [BYTE_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 tx_req_o;
  logic                 addr_match_o;
  logic                 rw_o;

  modport slave (
    input  sda_i,
    input  scl_i,
    input  start_detected_i,
    input  transfer_in_progress_i,
    input  tx_data_i,
    output sda_oe_o,
    output rx_data_o,
    output rx_valid_o,
    output tx_req_o,
    output addr_match_o,
    output rw_o
  );

  modport master (
    output sda_i,
    output scl_i,
    output start_detected_i,
    output transfer_in_progress_i,
    output tx_data_i,
    input  sda_oe_o,
    input  rx_data_o,
    input  rx_valid_o,
    input  tx_req_o,
    input  addr_match_o,
    input  rw_o
  );

endinterface

// File: rtl/scl_edge_detector.sv
// SCL edge detector: one-register delay line, rise/fall are combinational off scl_i.
// Edges are reported in the same cycle scl_i changes; no backpressure.
module scl_edge_detector (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic scl_i,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  logic r_scl_q;

  // Reset to 1 so an idle-high bus does not look like a rising edge.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_scl_q <= 1'b1;
    end else begin
      r_scl_q <= scl_i;
    end
  end

  assign scl_rise_o = scl_i & ~r_scl_q;
  assign scl_fall_o = ~scl_i & r_scl_q;

endmodule

// File: rtl/i2c_slave_shifter.sv
// Byte-level I2C slave: address match/ACK, write receive, read transmit; outputs registered, one cycle after the SCL edge.
// No stalling: tx_data_i is sampled at the SCL fall that starts a read byte, at least half an SCL period after tx_req_o.
module i2c_slave_shifter
  import i2c_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  i2c_slave_shifter_if.slave   i2c_if
);

  logic w_scl_rise;
  logic w_scl_fall;

  scl_edge_detector u_scl_edge (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .scl_i      (i2c_if.scl_i),
    .scl_rise_o (w_scl_rise),
    .scl_fall_o (w_scl_fall)
  );

  state_t               r_state;
  logic [3:0]           r_bit_cnt;
  logic [BYTE_BITS-1:0] r_shift;
  logic                 r_sda_oe;
  logic [BYTE_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_tx_req;
  logic                 r_addr_match;
  logic                 r_rw;

  logic [BYTE_BITS-1:0] w_byte_in;
  logic                 w_last_bit;
  logic                 w_byte_open;
  logic                 w_start;
  logic                 w_stop;

  assign w_byte_in   = {r_shift[BYTE_BITS-2:0], i2c_if.sda_i};
  assign w_last_bit  = (r_bit_cnt == (BIT_CNT_FULL - 4'd1));
  assign w_byte_open = (r_bit_cnt < BIT_CNT_FULL);
  assign w_start     = i2c_if.start_detected_i;
  assign w_stop      = ~i2c_if.transfer_in_progress_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= '0;
      r_sda_oe     <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_tx_req     <= 1'b0;
      r_addr_match <= 1'b0;
      r_rw         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;

      // Start and stop swallow any SCL edge seen in the same cycle.
      if (w_start) begin
        r_state      <= ADDR;
        r_bit_cnt    <= 4'd0;
        r_sda_oe     <= 1'b0;
        r_addr_match <= 1'b0;
      end else if (w_stop) begin
        r_state      <= IDLE;
        r_sda_oe     <= 1'b0;
        r_addr_match <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_sda_oe <= 1'b0;
          end

          ADDR: begin
            if (w_scl_rise && w_byte_open) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                if (addr_hit(w_byte_in, SLAVE_ADDR)) begin
                  r_addr_match <= 1'b1;
                  r_rw         <= w_byte_in[0];
                  r_tx_req     <= w_byte_in[0];
                end else begin
                  r_state <= IGNORE;
                end
              end
            end else if (w_scl_fall && !w_byte_open && r_addr_match) begin
              r_sda_oe <= 1'b1;
              r_state  <= ADDR_ACK;
            end
          end

          // Also entered after a master ACK in a read, to load the next byte.
          ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_shift  <= i2c_if.tx_data_i;
                r_sda_oe <= ~i2c_if.tx_data_i[BYTE_BITS-1];
                r_state  <= RD_DATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= WR_DATA;
              end
            end
          end

          WR_DATA: begin
            if (w_scl_rise && w_byte_open) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                r_rx_data  <= w_byte_in;
                r_rx_valid <= 1'b1;
              end
            end else if (w_scl_fall && !w_byte_open) begin
              r_sda_oe <= 1'b1;
              r_state  <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= WR_DATA;
            end
          end

          RD_DATA: begin
            if (w_scl_rise && w_byte_open) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (w_byte_open) begin
                r_shift  <= {r_shift[BYTE_BITS-2:0], 1'b0};
                r_sda_oe <= ~r_shift[BYTE_BITS-2];
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= RD_ACK;
              end
            end
          end

          RD_ACK: begin
            if (w_scl_rise) begin
              if (!i2c_if.sda_i) begin
                r_tx_req <= 1'b1;
                r_state  <= ADDR_ACK;
              end else begin
                r_state <= IGNORE;
              end
            end
          end

          IGNORE: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_if.sda_oe_o     = r_sda_oe;
  assign i2c_if.rx_data_o    = r_rx_data;
  assign i2c_if.rx_valid_o   = r_rx_valid;
  assign i2c_if.tx_req_o     = r_tx_req;
  assign i2c_if.addr_match_o = r_addr_match;
  assign i2c_if.rw_o         = r_rw;

endmodule

// File: doc/i2c_slave_shifter.md
Name: i2c_slave_shifter

Overview:
- Byte-level I2C slave engine directly downstream of transfer_detector.
- Consumes transfer_in_progress_o and start_detected plus the synchronized SDA/SCL lines, and performs these jobs:
  - shifts the address byte in and compares it with the slave address;
  - acknowledges it;
  - in write transfers, receives data bytes and ACKs each one;
  - in read transfers, shifts out bytes supplied by the register layer.
- Drives the open-drain SDA pull-down enable; the top level owns the tristate pad.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit slave address matched against address byte bits [7:1].

Ports:
- clk_i  input  1  system clock, same domain as transfer_detector.
- reset_n_i  input  1  synchronous, active-low reset.
- sda_i  input  1  SDA, already synchronized to clk_i.
- scl_i  input  1  SCL, already synchronized to clk_i.
- start_detected_i  input  1  one-cycle start/restart pulse from start_stop_detector.
- transfer_in_progress_i  input  1  from transfer_detector.
- tx_data_i  input  8  byte to transmit in read transfers.
- sda_oe_o  output  1  1 = pull SDA low; 0 = release.
- rx_data_o  output  8  last received data byte.
- rx_valid_o  output  1  one-cycle pulse; rx_data_o is valid.
- tx_req_o  output  1  one-cycle pulse requesting the next tx_data_i.
- addr_match_o  output  1  high from an address match until stop or restart.
- rw_o  output  1  R/W bit of the matched address byte (1 = read).

Behaviour:
- Reset (reset_n_i=0 at a clk_i edge):
  - state=IDLE, bit_cnt=0, shift register=0, scl_q=1.
  - All outputs are 0.
- Edge detection:
  - scl_q registers scl_i.
  - scl_rise = scl_i & ~scl_q; scl_fall = ~scl_i & scl_q.
- Priority each cycle: reset > start_detected_i > ~transfer_in_progress_i > SCL edges.
- start_detected_i (any state): go to ADDR, bit_cnt=0, sda_oe_o=0, addr_match_o=0.
- transfer_in_progress_i=0 (stop): go to IDLE, sda_oe_o=0, addr_match_o=0.
- An SCL edge in the same cycle as start or stop is ignored.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR:
  - On scl_rise, shift sda_i in MSB-first and increment bit_cnt.
  - At the 8th rise, compare bits [7:1] with SLAVE_ADDR.
    - Match: addr_match_o=1 and rw_o=bit0 in the same cycle. If read, tx_req_o pulses in that cycle.
    - Mismatch: go to IGNORE.
  - On the next scl_fall after a match: sda_oe_o=1, go to ADDR_ACK.
- ADDR_ACK, on scl_fall:
  - Write: sda_oe_o=0, bit_cnt=0, go to WR_DATA.
  - Read: load tx_data_i into the shift register, sda_oe_o=~tx_data_i[7], bit_cnt=0, go to RD_DATA.
- WR_DATA:
  - Shift on scl_rise.
  - At the 8th rise: rx_data_o=the assembled byte, rx_valid_o pulses for one cycle.
  - On the next scl_fall: sda_oe_o=1, go to WR_ACK.
- WR_ACK, on scl_fall: sda_oe_o=0, bit_cnt=0, go to WR_DATA.
- RD_DATA:
  - bit_cnt increments on scl_rise.
  - On scl_fall:
    - If bit_cnt<8: shift left and set sda_oe_o=~next MSB.
    - If bit_cnt==8: sda_oe_o=0, go to RD_ACK.
- RD_ACK, on scl_rise, sample sda_i:
  - 0 (master ACK): tx_req_o pulses, go to ADDR_ACK-equivalent load on the next scl_fall (load tx_data_i, then RD_DATA).
  - 1 (NACK): go to IGNORE.
- IGNORE: sda_oe_o=0; no shifting until start or stop.
- tx_data_i timing: sampled only at the scl_fall that begins a byte. The requester has at least half an SCL period after tx_req_o to supply it.
- sda_oe_o changes only on scl_fall, start, stop or reset, and is never asserted while SCL is high, except when it was asserted before the rise.
- bit_cnt is 4 bits wide and never exceeds 8.

Decomposition:
- Shared package i2c_pkg:
  - state encoding localparams;
  - BYTE_BITS=8;
  - ADDR_BITS=7.
- One natural sub-module: scl_edge_detector (scl_q register, scl_rise/scl_fall). Everything else is inline FSM plus datapath.

Test Plan:
- Write to 0x50: start, address 0xA0, data 0x3C, stop:
  - sda_oe_o=1 during both 9th clocks;
  - rx_valid_o pulses once with rx_data_o=0x3C;
  - addr_match_o falls at stop.
- Address mismatch: start, address 0xA2:
  - sda_oe_o stays 0 for the whole transfer;
  - no rx_valid_o; addr_match_o=0.
- Read from 0x50: start, 0xA1, tx_data_i=0x96, master ACK, tx_data_i=0x0F, master NACK, stop:
  - SDA pulled low exactly for the 0 bits of 0x96 then 0x0F;
  - tx_req_o pulses twice;
  - IGNORE after the NACK.
- Restart mid-write: start, 0xA0, 0x12, then start, 0xA1:
  - FSM re-enters ADDR;
  - rw_o=1, read proceeds;
  - only one rx_valid_o (0x12).
- Reset mid-ACK: assert reset_n_i=0 while sda_oe_o=1:
  - next cycle sda_oe_o=0 and all outputs 0;
  - no ACK until a new start.
- Start coincident with scl_fall: start_detected_i and scl_fall in the same cycle during WR_DATA:
  - state=ADDR, bit_cnt=0;
  - the edge is ignored.
